// File: rtl/airfield_aircraft_responder.sv
// Aircraft-side runway responder: sequences one departure through WAIT/ARM/ROLL/CLEAR.
// Optional lamp-code checker enabled by defining AIRFIELD_SIG_CHECK_EN.
module airfield_aircraft_responder #(
  parameter int ROLL_CYCLES     = 16,
  parameter int CLEAR_CYCLES    = 4,
  parameter int BOARD_PER_PLANE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] led1,
  input  logic [2:0] led2,
  input  logic       board_pulse,
  input  logic       depart_req,
  output logic [5:0] passengers,
  output logic       airfield,
  output logic [2:0] state,
  output logic       grant_ack,
  output logic       sig_err
);

  localparam int CNT_MAX = (ROLL_CYCLES > CLEAR_CYCLES) ? ROLL_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ROLL_FULL  = CNT_W'(ROLL_CYCLES);
  localparam logic [CNT_W-1:0] ROLL_HALF  = CNT_W'(ROLL_CYCLES / 2);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [6:0]       BOARD_DEC  = 7'(BOARD_PER_PLANE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARM   = 3'd2,
    ST_ROLL  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [5:0]       pass_r, pass_s;
  logic             airfield_r, airfield_s;
  logic             grant_r, grant_s;
  logic             dec_s;
  logic             go1_s, expedite_s;
  logic [6:0]       sum_s, net_s;

  // Anything other than a clean green is red; only a clean yellow expedites.
  assign go1_s      = (led1 == 3'b001);
  assign expedite_s = (led2 == 3'b100);

  // Next-state, phase counter and departure pulses.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    grant_s = 1'b0;
    dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (depart_req) state_s = ST_WAIT;
        else            state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (!depart_req) state_s = ST_IDLE;
        else if (go1_s)  state_s = ST_ARM;
        else             state_s = ST_WAIT;
      end
      ST_ARM: begin
        if (!depart_req) begin
          state_s = ST_IDLE;
        end else if (go1_s) begin
          state_s = ST_ROLL;
          grant_s = 1'b1;
          if (expedite_s) cnt_s = ROLL_HALF;
          else            cnt_s = ROLL_FULL;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ROLL: begin
        // Lamps and request are deliberately ignored while on the runway.
        if (cnt_r <= CNT_ONE) begin
          state_s = ST_CLEAR;
          cnt_s   = CLEAR_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          dec_s   = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    airfield_s = (state_s == ST_ROLL) || (state_s == ST_CLEAR);
  end

  // Passenger count: boarding and departure net out in one clamped update.
  always_comb begin
    sum_s = {1'b0, pass_r} + {6'd0, board_pulse};
    if (dec_s) begin
      if (sum_s < BOARD_DEC) net_s = 7'd0;
      else                   net_s = sum_s - BOARD_DEC;
    end else begin
      net_s = sum_s;
    end
    if (net_s > 7'd63) pass_s = 6'd63;
    else               pass_s = net_s[5:0];
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      pass_r     <= 6'd0;
      airfield_r <= 1'b0;
      grant_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pass_r     <= pass_s;
      airfield_r <= airfield_s;
      grant_r    <= grant_s;
    end
  end

`ifdef AIRFIELD_SIG_CHECK_EN
  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  logic sig_err_r;

  // Sticky flag for any non-one-hot lamp code, sampled in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_err_r <= 1'b0;
    end else begin
      sig_err_r <= sig_err_r | ~is_one_hot(led1) | ~is_one_hot(led2);
    end
  end

  assign sig_err = sig_err_r;
`else
  assign sig_err = 1'b0;
`endif

  assign state      = state_r;
  assign passengers = pass_r;
  assign airfield   = airfield_r;
  assign grant_ack  = grant_r;

endmodule

// File: doc/airfield_aircraft_responder.md
# airfield_aircraft_responder

Aircraft-side responder for the airfield signalling interface. It decodes the runway-controller lamp codes (`led1`, `led2`) and sequences one departing aircraft at a time through wait, arm, roll and clear phases. It drives the runway-occupied flag `airfield` and the waiting-area passenger count `passengers`, which feed back into the runway controller. It sits between the boarding-gate pulse source, the pilot request input, and the runway controller.

## Interface
Parameters:
- `ROLL_CYCLES`, 16, runway roll duration in cycles; must be even and ≥ 4.
- `CLEAR_CYCLES`, 4, runway-clear hold after roll, in cycles; must be ≥ 1.
- `BOARD_PER_PLANE`, 20, passengers removed from the waiting area per departure; range 1–63.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `led1`  in  3  runway lamp: bit0 green (go), bit1 red (wait), bit2 yellow (caution).
- `led2`  in  3  approach lamp, same encoding.
- `board_pulse`  in  1  one passenger enters the waiting area; one count per high cycle.
- `depart_req`  in  1  level request; aircraft ready to depart.
- `passengers`  out  6  waiting-area count, saturating.
- `airfield`  out  1  runway occupied (1 = plane on runway).
- `state`  out  3  current FSM state code.
- `grant_ack`  out  1  one-cycle pulse when the roll starts.
- `sig_err`  out  1  sticky illegal-lamp-code flag (see Configuration).

## Operation
- Reset: all outputs are registered and reset to 0. `state` resets to IDLE. `passengers` resets to 0. `airfield`, `grant_ack` and `sig_err` reset to 0. Internal counters reset to 0.
- A lamp code is **go** only when it equals exactly 3'b001. Every other code, including illegal non-one-hot codes, is treated as red.
- State codes: IDLE=0, WAIT=1, ARM=2, ROLL=3, CLEAR=4. Codes 5–7 are unreachable and recover to IDLE on the next edge.
- IDLE → WAIT when `depart_req`=1.
- WAIT:
  - → IDLE if `depart_req`=0.
  - → ARM if `led1` is go.
  - Otherwise stay.
- ARM (debounce; the go condition must hold on 2 consecutive edges):
  - → IDLE if `depart_req`=0. This takes priority.
  - → ROLL if `led1` is still go.
  - → WAIT otherwise.
- ARM → ROLL actions:
  - `grant_ack` pulses for exactly 1 cycle.
  - The roll counter loads `ROLL_CYCLES`, or `ROLL_CYCLES/2` if `led2`=3'b100 (yellow, expedite) on that edge.
- ROLL:
  - `airfield`=1.
  - Lamps are ignored, because the controller shows red in response to this block's own occupancy.
  - `depart_req` is ignored.
  - → CLEAR when the counter expires.
- CLEAR:
  - `airfield`=1 for `CLEAR_CYCLES` cycles, then → IDLE.
  - On the exiting edge, `passengers` is decremented by `BOARD_PER_PLANE`, clamped at 0.
- `passengers` arithmetic:
  - Computed in 7 bits as count + `board_pulse` − (dec ? `BOARD_PER_PLANE` : 0).
  - The result is clamped to the range 0..63.
  - A simultaneous increment and decrement nets out in a single update.
- Reset mid-operation: `airfield` drops asynchronously and the sequence is abandoned. No decrement is applied.

## Timing
- Go-to-occupied latency: `led1` go sampled at edge N (WAIT→ARM). It must also be go at edge N+1 (ARM→ROLL). `airfield` and `grant_ack` are high after edge N+1.
- `airfield` high time:
  - `ROLL_CYCLES + CLEAR_CYCLES` cycles normally.
  - `ROLL_CYCLES/2 + CLEAR_CYCLES` cycles when expedited.
- `passengers` updates the edge after the `board_pulse` cycle. The departure decrement appears on the same edge that `airfield` falls.
- Back-to-back departures: with `depart_req` held high, IDLE lasts 1 cycle, then WAIT.
- `sig_err` asserts on the edge after the illegal code is sampled.

## Configuration
- `AIRFIELD_SIG_CHECK_EN` defined:
  - Any non-one-hot value on `led1` or `led2` (including 0) is sampled in every state.
  - Such a value sets `sig_err`, which stays 1 until reset.
- Not defined: `sig_err` is tied to 0 and no checker logic is present.
- In both cases, illegal codes are treated as red for FSM decisions.

## Test plan
- Reset, then `depart_req`=1 and `led1`=001 steady → `grant_ack` pulses on the 3rd edge. `airfield`=1 for 20 cycles (16+4). `state` sequence is 0,1,2,3,…,4,0.
- In ARM, `led1` goes 001 → 010 → back to WAIT with no `grant_ack`. Then 2 edges of green → roll starts.
- `led2`=100 on the ARM→ROLL edge → `airfield` high for 12 cycles (8+4).
- 25 `board_pulse` cycles → `passengers`=25. Departure → 5. A `board_pulse` on the exit edge instead → 6. Starting from `passengers`=10 → 0 after departure.
- 70 `board_pulse` cycles → `passengers` saturates at 63. `rst_n` pulsed low during ROLL → `airfield`=0 immediately, `passengers`=0, `state`=0.
- With `AIRFIELD_SIG_CHECK_EN`: `led1`=011 for 1 cycle → `sig_err`=1 and held. Without the macro: same stimulus → `sig_err`=0, FSM treats it as red.
